// File: rtl/game_pkg.sv
// game_pkg: shared game/mode/sequencer enums and default timing constants.
package game_pkg;
    typedef enum logic [2:0] {START, KEEPER, SHOOTER, WINNER, LOSER} g_state;
    typedef enum logic {SOLO, MULTI} g_mode;
    typedef enum logic [2:0] {S_IDLE, S_KEEPER, S_SHOOTER, S_PAUSE, S_END} seq_state_t;
    localparam int unsigned TURN_CYCLES_DEF  = 390_000_000;
    localparam int unsigned PAUSE_CYCLES_DEF = 65_000_000;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: 32-bit loadable down-counter; expired is high on the last counted cycle.
module cycle_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        expired
);
    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? value : (cnt_q != 32'd0 ? cnt_q - 32'd1 : cnt_q);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = cnt_q == 32'd1;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: penalty match FSM alternating KEEPER/SHOOTER turns with inter-round pause.
// Optional turn timeout is enabled by defining ROUND_SEQ_TURN_TIMEOUT_EN.
module round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TURN_CYCLES  = TURN_CYCLES_DEF,
    parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  g_mode      game_mode,
    input  logic       start_req,
    input  logic       first_keeper,
    input  logic       round_done_gk,
    input  logic       round_done_sh,
    input  logic       enemy_input,
    input  logic       match_end,
    input  logic       match_result,
    input  logic       restart_req,
    output g_state     game_state,
    output logic [3:0] round_cnt,
    output logic       pause_active,
    output logic       turn_timeout
);
    seq_state_t state_q, state_d;
    g_state     game_state_q, game_state_d;
    logic [3:0] round_cnt_q, round_cnt_d;
    logic       timeout_q, timeout_d;
    logic       done, pause_load, pause_exp, turn_exp;

    cycle_timer u_pause (.clk, .rst, .load(pause_load), .value(32'(PAUSE_CYCLES)), .expired(pause_exp));

`ifdef ROUND_SEQ_TURN_TIMEOUT_EN
    logic turn_load;
    assign turn_load = (state_d == S_KEEPER || state_d == S_SHOOTER) && state_d != state_q;
    cycle_timer u_turn (.clk, .rst, .load(turn_load), .value(32'(TURN_CYCLES)), .expired(turn_exp));
`else
    assign turn_exp = (TURN_CYCLES == 0) & 1'b0;
`endif

    always_comb begin
        done = state_q == S_KEEPER  ? round_done_gk
             : state_q == S_SHOOTER ? (game_mode == SOLO ? round_done_sh : enemy_input) : 1'b0;
        state_d      = state_q;
        game_state_d = game_state_q;
        round_cnt_d  = round_cnt_q;
        timeout_d    = 1'b0;
        pause_load   = 1'b0;
        case (state_q)
            S_IDLE: if (start_req) begin
                state_d      = first_keeper ? S_KEEPER : S_SHOOTER;
                game_state_d = first_keeper ? KEEPER : SHOOTER;
                round_cnt_d  = 4'd1;
            end
            S_KEEPER, S_SHOOTER: if (done || turn_exp) begin
                state_d    = S_PAUSE;
                pause_load = 1'b1;
                timeout_d  = !done;
            end
            // game_state keeps the finished role through the pause
            S_PAUSE: if (pause_exp) begin
                if (match_end) begin
                    state_d      = S_END;
                    game_state_d = match_result ? WINNER : LOSER;
                end else begin
                    state_d      = game_state_q == KEEPER ? S_SHOOTER : S_KEEPER;
                    game_state_d = game_state_q == KEEPER ? SHOOTER : KEEPER;
                    round_cnt_d  = round_cnt_q == 4'd15 ? round_cnt_q : round_cnt_q + 4'd1;
                end
            end
            S_END: if (restart_req) begin
                state_d      = S_IDLE;
                game_state_d = START;
                round_cnt_d  = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            game_state_q <= START;
            round_cnt_q  <= 4'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_state_q <= game_state_d;
            round_cnt_q  <= round_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign game_state   = game_state_q;
    assign round_cnt    = round_cnt_q;
    assign pause_active = state_q == S_PAUSE;
    assign turn_timeout = timeout_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: randomized match flows checked against a round-level expectation model.
module tb_round_sequencer;
    import game_pkg::*;
    localparam int P = 5;
    localparam int T = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    g_mode game_mode = SOLO;
    logic start_req = 0, first_keeper = 0, round_done_gk = 0, round_done_sh = 0;
    logic enemy_input = 0, match_end = 0, match_result = 0, restart_req = 0;
    g_state game_state;
    logic [3:0] round_cnt;
    logic pause_active, turn_timeout;

    int checks = 0;
    int errors = 0;
    g_state exp_gs = START;
    int exp_rc = 0;

    round_sequencer #(.TURN_CYCLES(T), .PAUSE_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .game_mode(game_mode), .start_req(start_req),
        .first_keeper(first_keeper), .round_done_gk(round_done_gk),
        .round_done_sh(round_done_sh), .enemy_input(enemy_input),
        .match_end(match_end), .match_result(match_result), .restart_req(restart_req),
        .game_state(game_state), .round_cnt(round_cnt),
        .pause_active(pause_active), .turn_timeout(turn_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        start_req = 0; round_done_gk = 0; round_done_sh = 0; enemy_input = 0; restart_req = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag, logic pa, logic to);
        chk({tag, " game_state"}, {29'd0, game_state}, {29'd0, exp_gs});
        chk({tag, " round_cnt"}, {28'd0, round_cnt}, exp_rc);
        chk({tag, " pause_active"}, {31'd0, pause_active}, {31'd0, pa});
        chk({tag, " turn_timeout"}, {31'd0, turn_timeout}, {31'd0, to});
    endtask

    // Inputs that must not end the current turn
    task automatic noise_turn();
        logic [3:0] r = 4'($urandom);
        if (exp_gs == KEEPER) begin round_done_sh = r[0]; enemy_input = r[1]; end
        else if (game_mode == SOLO) begin round_done_gk = r[0]; enemy_input = r[1]; end
        else begin round_done_gk = r[0]; round_done_sh = r[1]; end
        start_req = r[2]; restart_req = r[3];
        match_end = 1'($urandom); first_keeper = 1'($urandom);
    endtask

    task automatic noise_all(bit allow_start, bit allow_restart);
        logic [6:0] r = 7'($urandom);
        round_done_gk = r[0]; round_done_sh = r[1]; enemy_input = r[2];
        start_req = r[3] & allow_start; restart_req = r[4] & allow_restart;
        match_end = r[5]; match_result = r[6]; first_keeper = 1'($urandom);
    endtask

    task automatic play_round(bit last);
        int gap = $urandom_range(0, 6);
        bit res;
        repeat (gap) begin noise_turn(); tick(); chk_all("turn hold", 0, 0); end
        if (exp_gs == KEEPER) round_done_gk = 1;
        else if (game_mode == SOLO) round_done_sh = 1;
        else enemy_input = 1;
        tick();
        chk_all("pause entry", 1, 0);
        for (int i = 2; i <= P; i++) begin noise_all(1, 1); tick(); chk_all("pause hold", 1, 0); end
        noise_all(1, 1);
        res = 1'($urandom);
        match_end = last;
        match_result = res;
        tick();
        match_end = 0;
        if (last) exp_gs = res ? WINNER : LOSER;
        else begin
            exp_gs = exp_gs == KEEPER ? SHOOTER : KEEPER;
            exp_rc = exp_rc < 15 ? exp_rc + 1 : 15;
        end
        chk_all("after pause", 0, 0);
    endtask

    task automatic play_match(int rounds);
        bit fk = 1'($urandom);
        game_mode = g_mode'($urandom_range(0, 1));
        repeat ($urandom_range(0, 3)) begin noise_all(0, 1); tick(); chk_all("idle hold", 0, 0); end
        first_keeper = fk;
        start_req = 1;
        tick();
        exp_gs = fk ? KEEPER : SHOOTER;
        exp_rc = 1;
        chk_all("start", 0, 0);
        for (int r = 1; r <= rounds; r++) play_round(r == rounds);
        repeat (3) begin noise_all(1, 0); tick(); chk_all("end hold", 0, 0); end
        restart_req = 1;
        tick();
        exp_gs = START;
        exp_rc = 0;
        chk_all("restart", 0, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_all("in reset", 0, 0);
        rst = 0;
        tick();
        chk_all("after reset", 0, 0);
        play_match(1);
        play_match(3);
        play_match(17);
        repeat (4) play_match($urandom_range(1, 6));

        // reset during pause cycle 3
        game_mode = SOLO; first_keeper = 1; start_req = 1;
        tick();
        exp_gs = KEEPER; exp_rc = 1;
        chk_all("rst-pause start", 0, 0);
        round_done_gk = 1;
        tick();
        chk_all("rst-pause p1", 1, 0);
        tick();
        tick();
        chk_all("rst-pause p3", 1, 0);
        rst = 1;
        tick();
        rst = 0;
        exp_gs = START; exp_rc = 0;
        chk_all("rst-pause", 0, 0);

`ifdef ROUND_SEQ_TURN_TIMEOUT_EN
        game_mode = MULTI; first_keeper = 0; start_req = 1;
        tick();
        exp_gs = SHOOTER; exp_rc = 1;
        repeat (T - 1) begin round_done_sh = 1'($urandom); tick(); chk_all("to wait", 0, 0); end
        tick();
        chk_all("to pulse", 1, 1);
        tick();
        chk_all("to pulse end", 1, 0);
        repeat (3) tick();
        tick();
        exp_gs = KEEPER; exp_rc = 2;
        chk_all("to next role", 0, 0);
        repeat (T - 1) tick();
        chk_all("to keeper wait", 0, 0);
        round_done_gk = 1;
        tick();
        chk_all("to done wins", 1, 0);
        tick();
        chk_all("to done no pulse", 1, 0);
`else
        game_mode = SOLO; first_keeper = 0; start_req = 1;
        tick();
        exp_gs = SHOOTER; exp_rc = 1;
        repeat (2 * T) tick();
        chk_all("no timeout", 0, 0);
`endif
        rst = 1;
        tick();
        rst = 0;
        exp_gs = START; exp_rc = 0;
        chk_all("final reset", 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequencer for the penalty match flow that drives `game_state` into the score controller and the keeper/shooter gameplay blocks. It leaves START on a start request and alternates KEEPER and SHOOTER turns. After each round it inserts a fixed inter-round pause, then ends the match in WINNER or LOSER once the score controller raises `match_end`. It sits between the top-level input/UART glue and the score/gameplay datapath. It is the only writer of `game_state`.

## Interface
- `TURN_CYCLES`, default 390_000_000, turn length limit in clocks (6 s at 65 MHz); used only with the timeout feature.
- `PAUSE_CYCLES`, default 65_000_000, inter-round pause length in clocks; must be ≥ 4.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `game_mode`  in  g_mode  SOLO/MULTI, sampled continuously.
- `start_req`  in  1  single-cycle pulse; starts the match from START.
- `first_keeper`  in  1  role for round 1, sampled with `start_req`: 1 = KEEPER, 0 = SHOOTER.
- `round_done_gk`  in  1  keeper round finished (pulse).
- `round_done_sh`  in  1  own shot round finished (pulse); used in SOLO only.
- `enemy_input`  in  1  opponent finished its keeper action (pulse); ends the SHOOTER round in MULTI.
- `match_end`, `match_result`  in  1 each  come from the score controller (registered there).
- `restart_req`  in  1  pulse; returns from WINNER/LOSER to START.
- `game_state`  out  g_state  registered; reset value START.
- `round_cnt`  out  4  current round, 1-based, saturates at 15; reset value 0.
- `pause_active`  out  1  high during the inter-round pause; reset value 0.
- `turn_timeout`  out  1  one-cycle pulse when a turn expires; reset value 0.

## Operation
- Internal FSM `seq_state_t` has five states: S_IDLE, S_KEEPER, S_SHOOTER, S_PAUSE, S_END.
- Mapping to `game_state`:
  - S_IDLE drives START.
  - S_KEEPER and S_SHOOTER drive KEEPER and SHOOTER.
  - S_PAUSE holds the role of the round that just finished. The score controller clears scores outside KEEPER/SHOOTER, so the role must be held.
  - S_END drives WINNER when `match_result`=1, otherwise LOSER; latched on entry.
- S_IDLE → first role on `start_req`; sets `round_cnt`=1. `start_req` is ignored in every other state.
- Round-complete event:
  - S_KEEPER: `round_done_gk` in both modes.
  - S_SHOOTER: `round_done_sh` in SOLO, `enemy_input` in MULTI.
  - An event moves the FSM to S_PAUSE and loads the pause timer with PAUSE_CYCLES.
- S_PAUSE, on the last pause cycle:
  - if `match_end`=1 → S_END;
  - otherwise → the opposite role, and `round_cnt`+1 (saturating).
- S_END → S_IDLE on `restart_req`; `round_cnt` returns to 0.
- Completion inputs that arrive outside the state expecting them are ignored. Examples: `round_done_sh` in S_KEEPER, or any input during S_PAUSE.
- `rst` asserted in any state, including mid-pause or mid-turn, forces S_IDLE with all outputs at reset values on the next edge.

## Timing
- `game_state` changes on the clock edge after the triggering input cycle: 1-cycle latency.
- The pause lasts exactly PAUSE_CYCLES clocks, during which `pause_active`=1.
- `match_end` is sampled only on the final pause cycle. PAUSE_CYCLES ≥ 4 guarantees the score controller's 2-register path has settled.
- If a completion event and timer expiry fall in the same cycle, the completion wins and no `turn_timeout` pulse is produced.
- The turn timer restarts at 0 on every entry to S_KEEPER or S_SHOOTER.

## Configuration
- Macro: `ROUND_SEQ_TURN_TIMEOUT_EN`.
- Defined:
  - a turn counter runs in S_KEEPER/S_SHOOTER;
  - at count TURN_CYCLES−1 with no completion event, `turn_timeout` pulses for 1 cycle and the FSM enters S_PAUSE as if the round had completed;
  - scoring of a timed-out round is left to the gameplay blocks, which observe `turn_timeout`.
- Undefined: no turn counter is synthesized, `turn_timeout` is tied 0, and turns last indefinitely.

## Structure
- `game_pkg` holds the following; `g_state` and `g_mode` are reused unchanged:
  - `seq_state_t`;
  - default constants `TURN_CYCLES_DEF` and `PAUSE_CYCLES_DEF`.
- One sub-module, `cycle_timer`: a 32-bit loadable down-counter with `load`, `value` and a one-cycle `expired` pulse.
  - One instance serves as the pause timer.
  - A second instance serves as the turn timer and exists only under the macro.

## Test plan
All scenarios use PAUSE_CYCLES=5 and TURN_CYCLES=20.
- Reset, then `start_req` with `first_keeper`=1 → `game_state`=KEEPER on the next cycle, `round_cnt`=1, all other outputs 0.
- SOLO, `round_done_gk` pulse in KEEPER → `pause_active`=1 for exactly 5 cycles with `game_state`=KEEPER held, then `game_state`=SHOOTER and `round_cnt`=2.
- MULTI in SHOOTER: `round_done_sh` pulse has no effect; a later `enemy_input` pulse → pause, then KEEPER.
- `match_end`=1 and `match_result`=1 during a pause → WINNER after the pause. `restart_req` → START with `round_cnt`=0. Repeating with `match_result`=0 → LOSER.
- Macro defined, no completion input for 20 cycles in SHOOTER → `turn_timeout` pulse on cycle 20, then pause, then KEEPER. A `round_done_sh` on the expiry cycle produces no pulse.
- Assert `rst` on pause cycle 3 → next cycle `game_state`=START, `pause_active`=0, `round_cnt`=0.
